// File: rtl/data_memory_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous data memory.
// Each accepted command holds the memory for 2 cycles (write) or 3 cycles (read), and every output is registered.
module data_memory_arbiter #(
  parameter int DATA_W = 72,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2
  } state_t;

  // Handshake: a requester raises req with we/addr/wdata stable and keeps them until it
  // sees its one-cycle gnt; a read then returns one rvalid pulse two cycles after gnt.

  state_t state, state_n;
  logic   sel, sel_n;    // requester that owns the transaction in flight
  logic   last, last_n;  // requester granted most recently
  logic   pick;

  logic              gnt0_n, gnt1_n, rvalid0_n, rvalid1_n;
  logic              mem_en_n, mem_we_n, busy_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n, rdata0_n, rdata1_n;

  always_comb begin
    state_n     = state;
    sel_n       = sel;
    last_n      = last;
    pick        = 1'b0;
    gnt0_n      = 1'b0;
    gnt1_n      = 1'b0;
    rvalid0_n   = 1'b0;
    rvalid1_n   = 1'b0;
    mem_en_n    = 1'b0;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    rdata0_n    = rdata0;
    rdata1_n    = rdata1;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not granted last wins; a lone requester always wins.
          pick        = (req0 && req1) ? ~last : req1;
          sel_n       = pick;
          last_n      = pick;
          mem_en_n    = 1'b1;
          mem_we_n    = pick ? we1 : we0;
          mem_addr_n  = pick ? addr1 : addr0;
          mem_wdata_n = pick ? wdata1 : wdata0;
          gnt0_n      = ~pick;
          gnt1_n      = pick;
          state_n     = ISSUE;
        end
      end
      ISSUE: state_n = mem_we ? IDLE : RWAIT;
      RWAIT: begin
        if (sel) begin
          rdata1_n  = mem_rdata;
          rvalid1_n = 1'b1;
        end else begin
          rdata0_n  = mem_rdata;
          rvalid0_n = 1'b1;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= 1'b0;
      last      <= 1'b1;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      last      <= last_n;
      gnt0      <= gnt0_n;
      gnt1      <= gnt1_n;
      rvalid0   <= rvalid0_n;
      rvalid1   <= rvalid1_n;
      rdata0    <= rdata0_n;
      rdata1    <= rdata1_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      busy      <= busy_n;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: behavioural 128x72 memory, a shadow copy of expected contents,
// and per-requester read-data queues popped whenever an rvalid pulse appears.
module tb_data_memory_arbiter;
  localparam int DATA_W = 72;
  localparam int ADDR_W = 7;

  logic              clk, reset;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_en, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [1:0]        dbg_state;

  logic [DATA_W-1:0] mem [128];
  logic [DATA_W-1:0] exp_mem [128];
  logic [DATA_W-1:0] exp_q0[$];
  logic [DATA_W-1:0] exp_q1[$];
  int checks = 0;
  int errors = 0;

  data_memory_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural synchronous memory, read data one cycle after the strobe
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every rvalid pulse must match the oldest expected read for that requester
  always @(negedge clk) begin
    if (rvalid0) begin
      if (exp_q0.size() == 0) check("rvalid0_unexpected", 1, 0);
      else check("rdata0", rdata0, exp_q0.pop_front());
    end
    if (rvalid1) begin
      if (exp_q1.size() == 0) check("rvalid1_unexpected", 1, 0);
      else check("rdata1", rdata1, exp_q1.pop_front());
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, {gnt0, gnt1}, 0);
    check({tag, "_rvalid"}, {rvalid0, rvalid1}, 0);
    check({tag, "_mem_en_we"}, {mem_en, mem_we}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_state"}, dbg_state, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_rdata0"}, rdata0, 0);
    check({tag, "_rdata1"}, rdata1, 0);
  endtask

  // drive a request at a negedge and wait (bounded) for its grant
  task automatic drive_req(input bit id, input bit we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, output bit got);
    if (id) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    else    begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = id ? gnt1 : gnt0;
    end
    check("gnt_seen", got, 1);
    check("gnt_other", id ? gnt0 : gnt1, 0);
    check("mem_en_at_gnt", mem_en, 1);
    check("mem_we_at_gnt", mem_we, we);
    check("mem_addr_at_gnt", mem_addr, a);
    check("busy_at_gnt", busy, 1);
    if (we) check("mem_wdata_at_gnt", mem_wdata, d);
    req0 = 0; req1 = 0;
  endtask

  task automatic do_write(input bit id, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit got;
    drive_req(id, 1'b1, a, d, got);
    exp_mem[a] = d;
    @(negedge clk);
    check("wr_idle_after", {busy, dbg_state}, 0);
    check("wr_gnt_cleared", {gnt0, gnt1, mem_en}, 0);
    check("wr_addr_hold", mem_addr, a);
  endtask

  task automatic do_read(input bit id, input logic [ADDR_W-1:0] a);
    bit got;
    logic [DATA_W-1:0] junk;
    junk = '0;
    if (id) exp_q1.push_back(exp_mem[a]);
    else    exp_q0.push_back(exp_mem[a]);
    drive_req(id, 1'b0, a, junk, got);
    @(negedge clk);
    check("rd_rwait_busy", busy, 1);
    check("rd_no_early_rvalid", {rvalid0, rvalid1}, 0);
    @(negedge clk);
    check("rd_rvalid", id ? rvalid1 : rvalid0, 1);
    check("rd_rvalid_other", id ? rvalid0 : rvalid1, 0);
    check("rd_idle", busy, 0);
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) begin mem[i] = '0; exp_mem[i] = '0; end
    mem_rdata = '0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    reset = 1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 0;

    // single write, then a read returned to the other requester
    do_write(0, 7'h05, 72'hABC);
    do_write(0, 7'h10, 72'h123);
    do_read(1, 7'h10);
    @(negedge clk);
    check("rdata1_hold", rdata1, 72'h123);
    check("rvalid1_pulse_once", rvalid1, 0);

    // round-robin with both requesters writing continuously, straight out of reset
    reset = 1;
    @(negedge clk);
    reset = 0;
    req0 = 1; we0 = 1; addr0 = 7'h20; wdata0 = 72'h11;
    req1 = 1; we1 = 1; addr1 = 7'h21; wdata1 = 72'h22;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("rr_gnt0_%0d", i), gnt0, (i % 4) == 0);
      check($sformatf("rr_gnt1_%0d", i), gnt1, (i % 4) == 2);
    end
    req0 = 0; req1 = 0;
    exp_mem[7'h20] = 72'h11;
    exp_mem[7'h21] = 72'h22;

    // lone requester 1 right after its own grant is still served every time
    req1 = 1; we1 = 1; addr1 = 7'h22; wdata1 = 72'h33;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("lone_gnt1_%0d", i), gnt1, (i % 2) == 0);
      check($sformatf("lone_gnt0_%0d", i), gnt0, 0);
    end
    req1 = 0;
    exp_mem[7'h22] = 72'h33;
    do_read(0, 7'h20);
    do_read(1, 7'h22);

    // top address round trip
    begin
      logic [DATA_W-1:0] d;
      d = rand_data();
      do_write(0, 7'h7F, d);
      do_read(0, 7'h7F);
    end

    // random mix of reads and writes
    for (int n = 0; n < 20; n++) begin
      bit id;
      logic [ADDR_W-1:0] a;
      id = 1'($urandom_range(0, 1));
      a  = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) do_write(id, a, rand_data());
      else do_read(id, a);
    end

    // reset during RWAIT aborts the read with no rvalid afterwards
    begin
      bit got;
      logic [DATA_W-1:0] junk;
      junk = '0;
      drive_req(0, 1'b0, 7'h05, junk, got);
      @(negedge clk);
      check("abort_in_rwait", dbg_state, 2);
      reset = 1;
      @(negedge clk);
      check_all_zero("abort");
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("abort_no_rvalid", {rvalid0, rvalid1}, 0);
      end
    end

    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=0 expected=1");
    $fatal(1);
  end
endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 72, memory word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 7, word address width (128 words).
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  input  1  requester 0/1 access request, level.
REQ-006 SHALL have ports we0/we1  input  1  requester write (1) or read (0).
REQ-007 SHALL have ports addr0/addr1  input  ADDR_W  requester word address.
REQ-008 SHALL have ports wdata0/wdata1  input  DATA_W  requester write data.
REQ-009 SHALL have ports gnt0/gnt1  output  1  one-cycle grant pulse, command accepted.
REQ-010 SHALL have ports rvalid0/rvalid1  output  1  one-cycle read-data-valid pulse.
REQ-011 SHALL have ports rdata0/rdata1  output  DATA_W  read data, valid when rvalid high.
REQ-012 SHALL have port mem_en  output  1  memory access strobe.
REQ-013 SHALL have port mem_we  output  1  memory write enable, qualified by mem_en.
REQ-014 SHALL have ports mem_addr (ADDR_W) and mem_wdata (DATA_W)  output  memory command.
REQ-015 SHALL have port mem_rdata  input  DATA_W  memory read data, one cycle after mem_en read.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, RWAIT; all outputs registered.
REQ-018 In IDLE with any req high, SHALL select one requester, register its we/addr/wdata onto mem_*, set mem_en=1 and its gnt=1, go to ISSUE.
REQ-019 Both req high in IDLE SHALL grant the requester not granted last (round-robin); single req SHALL be granted regardless of pointer.
REQ-020 Last-grant pointer SHALL update only on a grant.
REQ-021 gnt and mem_en SHALL be high only during the ISSUE cycle (exactly one cycle per transaction).
REQ-022 ISSUE with mem_we=1 SHALL return to IDLE next edge; write occupies 2 cycles, no rvalid.
REQ-023 ISSUE with mem_we=0 SHALL go to RWAIT; in RWAIT, SHALL capture mem_rdata into the granted requester's rdata, pulse its rvalid for one cycle, return to IDLE.
REQ-024 Read latency SHALL be 3 cycles from req sampled in IDLE to rvalid high; rdata SHALL hold until the next read for that requester.
REQ-025 Requests SHALL be sampled only in IDLE; req held during ISSUE/RWAIT SHALL be treated as a new request at the next IDLE.
REQ-026 mem_addr/mem_wdata/mem_we SHALL hold their last values when mem_en=0; the memory ignores them.
REQ-027 Requesters SHALL hold we/addr/wdata stable while req high until gnt seen; arbiter need not check this.

Reset
REQ-028 While reset high: state=IDLE, gnt0/1=0, rvalid0/1=0, mem_en=0, mem_we=0, busy=0, mem_addr=0, mem_wdata=0, rdata0/1=0, pointer=1 (requester 0 wins first tie).
REQ-029 Reset during ISSUE or RWAIT SHALL abort the transaction; no rvalid SHALL be issued for it afterward.

Verification
REQ-030 req0=1 we0=1 addr0=0x05 wdata0=0xABC -> next cycle gnt0=1, mem_en=1, mem_we=1, mem_addr=0x05; IDLE 2 cycles after sampling.
REQ-031 req1 read addr 0x10, mem_rdata=0x123 in RWAIT -> rvalid1=1, rdata1=0x123 at cycle 3; rvalid0 stays 0.
REQ-032 After reset, req0=req1=1 continuously, both writes -> grants alternate 0,1,0,1, one grant every 2 cycles.
REQ-033 Only req1 high for 3 writes after a req1 grant -> gnt1 each time (pointer does not block a lone requester).
REQ-034 reset asserted during RWAIT of a read -> all outputs 0 next cycle, no rvalid ever for that read.
REQ-035 Write 0x7F then read 0x7F with behavioural 128x72 memory model -> rdata equals written data, mem_addr=0x7F both times.
